// File: rtl/rr_port_arbiter.sv
// Round-robin output-port arbiter: one-hot grant to the first addressed requester in pointer order, locked until tail.
// Latency: grant registered one cycle after a request in IDLE; next grant loads in the tail cycle (no bubble).
// Backpressure: out_ready_i low stalls xfer_o and holds the lock; RR_ARB_HOLD_LIMIT_EN adds a forced release after HOLD_LIMIT cycles.
module rr_port_arbiter #(
    parameter int                NUM_REQ    = 4,
    parameter int                ADDR_W     = 3,
    parameter logic [ADDR_W-1:0] PORT_ID    = 3'd3,
    parameter int                HOLD_LIMIT = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ*ADDR_W-1:0]     nexthop_addr_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            tail_i,
    input  logic                          out_ready_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          grant_valid_o,
    output logic [$clog2(NUM_REQ)-1:0]    grant_idx_o,
    output logic                          xfer_o,
    output logic                          forced_release_o
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   arb_ptr;
    logic [IDX_W-1:0]   ptr_nxt;
    logic               tail_rel;
    logic               hold_expired;
    logic               release_any;

    if (NUM_REQ < 2 || NUM_REQ > 8 || HOLD_LIMIT < 1) begin : g_param_check
        $error("rr_port_arbiter: NUM_REQ must be 2..8 and HOLD_LIMIT >= 1");
    end

    // First set bit at or above p wins; otherwise the lowest set bit below p (wrap-around).
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                   input logic [IDX_W-1:0]   p);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (r[i] && (i < int'(p))) begin
                oh    = '0;
                oh[i] = 1'b1;
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (r[i] && (i >= int'(p))) begin
                oh    = '0;
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    function automatic logic [IDX_W-1:0] oh_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

    // Decode which inputs are aiming a flit at this output port.
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i] = req_valid_i[i] && (nexthop_addr_i[i*ADDR_W +: ADDR_W] == PORT_ID);
        end
    end

    // The grant is only non-zero while locked, so these need no state qualifier.
    // Address is deliberately ignored here: a locked input keeps its path even if its address changes mid-packet.
    assign xfer_o      = out_ready_i && |(grant_q & req_valid_i);
    assign tail_rel    = out_ready_i && |(grant_q & req_valid_i & tail_i);
    assign release_any = tail_rel || hold_expired;
    assign ptr_nxt     = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

    // Next grant/pointer: arbitrate from IDLE with the current pointer, or in a release cycle with the advanced one.
    // On release the outgoing input is excluded: its valid in that cycle belongs to the packet just finished.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        arb_ptr = ptr_q;
        arb_req = req;
        if (state_q == ST_LOCKED && release_any) begin
            ptr_d   = ptr_nxt;
            arb_ptr = ptr_nxt;
            arb_req = req & ~grant_q;
        end
        pick     = rr_pick(arb_req, arb_ptr);
        pick_idx = oh_to_idx(pick);
        if (state_q == ST_IDLE || release_any) begin
            grant_d = pick;
            idx_d   = pick_idx;
            state_d = (|pick) ? ST_LOCKED : ST_IDLE;
        end
    end

`ifdef RR_ARB_HOLD_LIMIT_EN
    localparam int CNT_W = $clog2(HOLD_LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A tail in the limit cycle is an ordinary release, so it suppresses the forced one.
    assign hold_expired = (state_q == ST_LOCKED) && (cnt_q == CNT_W'(HOLD_LIMIT - 1)) && !tail_rel;

    // Lock age: zero on the first locked cycle after every grant load, advancing while the lock is held.
    always_comb begin
        cnt_d = (state_q == ST_LOCKED && !release_any) ? cnt_q + 1'b1 : '0;
    end
`else
    assign hold_expired = 1'b0;
`endif

    assign forced_release_o = hold_expired;

    // All arbiter state, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
`ifdef RR_ARB_HOLD_LIMIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
`ifdef RR_ARB_HOLD_LIMIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign grant_o       = grant_q;
    assign grant_valid_o = |grant_q;
    assign grant_idx_o   = idx_q;

endmodule

// File: doc/rr_port_arbiter.md
# rr_port_arbiter

Parametrised round-robin output-port arbiter for the NoC router. It is the next generation of the fixed 4-input per-port round-robin processor. Each input presents a next-hop address, and requests aimed at this block's port compete for a registered one-hot grant. The grant is held for a whole packet (lock until tail), and the rotating pointer advances one past the winner on release. One instance sits in front of each output port's crossbar select.

## Interface
Parameters:
- NUM_REQ, 4: number of requesting input ports, 2..8.
- ADDR_W, 3: width of each next-hop address.
- PORT_ID, 3'd3: address value that selects this output port (east).
- HOLD_LIMIT, 16: maximum lock duration in cycles. Used only with RR_ARB_HOLD_LIMIT_EN.

Ports:
- clk, input, 1: single clock. All state is on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- nexthop_addr_i, input, NUM_REQ*ADDR_W: per-input next-hop address; input i occupies bits [i*ADDR_W +: ADDR_W].
- req_valid_i, input, NUM_REQ: per-input flit valid.
- tail_i, input, NUM_REQ: per-input tail flag for the current flit.
- out_ready_i, input, 1: downstream can accept a flit this cycle.
- grant_o, output, NUM_REQ: registered one-hot grant, used as the crossbar select.
- grant_valid_o, output, 1: OR of grant_o.
- grant_idx_o, output, $clog2(NUM_REQ): binary index of the granted input. Holds 0 when there is no grant.
- xfer_o, output, 1: a flit transfers this cycle.
- forced_release_o, output, 1: one-cycle pulse on a hold-limit release.

## Operation
- Request: req[i] = req_valid_i[i] && (nexthop_addr_i[i] == PORT_ID).
- Pointer ptr ranges 0..NUM_REQ-1. Priority order is ptr, ptr+1, …, wrapping modulo NUM_REQ.
- The FSM has two states, IDLE and LOCKED.
- IDLE:
  - If any req is set, register a one-hot grant to the first requester in pointer order and go to LOCKED.
  - If no req is set, stay in IDLE with grant_o = 0.
- LOCKED:
  - Transfer: xfer_o = req_valid_i[g] && out_ready_i && grant_o[g], where g is the granted input.
  - A transfer with tail_i[g] set is a release: set ptr = (g+1) mod NUM_REQ.
  - In the release cycle, arbitrate among the current requests using the updated ptr. If any exist, load the new grant and stay in LOCKED. Otherwise go to IDLE.
  - Dropping req_valid_i[g] or changing its address mid-packet does not release the lock. The grant holds until the tail transfers.
- A single-flit packet (head is also tail) locks and releases on the same transfer cycle.
- The pointer changes only on release. Arbitrating from IDLE does not move it.

## Timing
- Reset values: grant_o = 0, grant_valid_o = 0, grant_idx_o = 0, xfer_o = 0, forced_release_o = 0, ptr = 0, state = IDLE.
- Grant latency: a request first seen in IDLE at cycle t produces a grant at t+1.
- Back-to-back packets have no bubble. After a tail transfer at cycle t, the next grant is visible at t+1.
- xfer_o is combinational from the registered grant and the current inputs.
- If reset is asserted mid-packet, all state clears asynchronously. After release, arbitration restarts from ptr 0.
- Simultaneous requests from every input, each sending single-flit packets, are granted in order ptr, ptr+1, …. Each input is served once per NUM_REQ packets.

## Configuration
- RR_ARB_HOLD_LIMIT_EN defined:
  - A counter counts cycles in LOCKED, resetting on each grant load.
  - When the count reaches HOLD_LIMIT without a tail transfer, the lock is force-released: ptr = (g+1) mod NUM_REQ, forced_release_o pulses for 1 cycle, and re-arbitration happens in the same cycle.
  - A tail transfer in the limit cycle counts as a normal release, and forced_release_o stays 0.
- RR_ARB_HOLD_LIMIT_EN not defined: no counter is built, forced_release_o is tied to 0, and the lock holds indefinitely.

## Test plan
- Reset, then input 0 requests (address 3) with a 3-flit packet and out_ready_i = 1. Expect grant_o = 0001 at cycle 1, xfer_o high for 3 cycles, ptr = 1 after the tail, and grant_o = 0 the cycle after.
- Inputs 0–3 all request with single-flit packets continuously. Expect the grant sequence 0001, 0010, 0100, 1000, 0001 with no idle cycles.
- Input 2 requests with address 1 (another port). Expect grant_o to stay 0.
- Input 1 is locked and input 3 requests. Toggle out_ready_i 1,0,0,1 and send the tail on the last ready cycle. Expect grant_o = 0010 throughout, then 1000.
- Input 0 is locked with its tail withheld, RR_ARB_HOLD_LIMIT_EN is defined, HOLD_LIMIT = 16, and input 2 is waiting. Expect forced_release_o to pulse at lock cycle 16 and grant_o = 0100 on the next cycle.
- Assert reset mid-packet on input 2. Expect grant_o = 0 immediately (asynchronous). After deassertion with inputs 1 and 3 requesting, expect grant_o = 0010 (ptr = 0).
